// File: rtl/apb4_pkg.sv
// Shared types and constants for the APB4 master bridge.
//   apb4_state_e       : bridge FSM state (idle, setup, access, response)
//   APB4_READ_STRB     : strobe value driven on the bus for read transfers
//   APB4_TIMEOUT_CNT_W : width of the optional ACCESS-phase timeout counter
package apb4_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSetup  = 2'd1,
    StAccess = 2'd2,
    StResp   = 2'd3
  } apb4_state_e;

  localparam logic [3:0] APB4_READ_STRB = 4'b0000;

  // Wide enough for any TIMEOUT_CYCLES in 2..255.
  localparam int unsigned APB4_TIMEOUT_CNT_W = 8;

endpackage

// File: rtl/apb4_timeout_cnt.sv
// ACCESS-phase timeout counter for the APB4 master bridge.
// Only instantiated when APB4_MASTER_TIMEOUT_EN is defined.
// Ports:
//   pclk    : clock, rising edge
//   preset  : synchronous active-high reset, clears the count
//   clr     : clear the count (asserted in the cycle before ACCESS is entered)
//   inc     : count one more ACCESS cycle without pready
//   expired : count has reached TIMEOUT_CYCLES-1
module apb4_timeout_cnt
  import apb4_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic pclk,
  input  logic preset,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  logic [APB4_TIMEOUT_CNT_W-1:0] count_q, count_d;

  assign expired = (count_q == APB4_TIMEOUT_CNT_W'(TIMEOUT_CYCLES - 1));

  // Saturate at the terminal value so the count never wraps back under it.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && !expired) begin
      count_d = count_q + APB4_TIMEOUT_CNT_W'(1);
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/apb4_master_bridge.sv
// Command/response to APB4 master bridge, one transaction outstanding.
// A command accepted in idle is registered onto the APB bus, runs one SETUP
// cycle, then ACCESS until pready; the result is held on rsp_* until
// rsp_ready. Reads always drive pstrb = 0.
// Optional feature: define APB4_MASTER_TIMEOUT_EN to abort an ACCESS phase
// that sees no pready for TIMEOUT_CYCLES cycles (rsp_err=1, rsp_timeout=1).
// Without it ACCESS waits forever and rsp_timeout is tied 0.
// Ports:
//   pclk, preset                         : clock, synchronous active-high reset
//   cmd_valid/cmd_ready                  : command handshake
//   cmd_write/addr/wdata/strb            : command payload
//   rsp_valid/rsp_ready                  : response handshake
//   rsp_rdata/rsp_err/rsp_timeout        : response payload
//   psel/penable/pwrite/paddr/pwdata/pstrb : APB request
//   prdata/pready/pslverr                : APB completion
module apb4_master_bridge #(
  parameter int unsigned ADDRWIDTH      = 12,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                 pclk,
  input  logic                 preset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [ADDRWIDTH-1:0] cmd_addr,
  input  logic [31:0]          cmd_wdata,
  input  logic [3:0]           cmd_strb,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_rdata,
  output logic                 rsp_err,
  output logic                 rsp_timeout,
  output logic                 psel,
  output logic                 penable,
  output logic                 pwrite,
  output logic [ADDRWIDTH-1:0] paddr,
  output logic [31:0]          pwdata,
  output logic [3:0]           pstrb,
  input  logic [31:0]          prdata,
  input  logic                 pready,
  input  logic                 pslverr
);

  import apb4_pkg::*;

  apb4_state_e          state_q, state_d;
  logic                 pwrite_q;
  logic [ADDRWIDTH-1:0] paddr_q;
  logic [31:0]          pwdata_q;
  logic [3:0]           pstrb_q;
  logic [31:0]          rsp_rdata_q;
  logic                 rsp_err_q;
  logic                 timeout_hit;

  // Bus and handshake controls decode straight from the state register.
  assign cmd_ready = (state_q == StIdle);
  assign rsp_valid = (state_q == StResp);
  assign psel      = (state_q == StSetup) || (state_q == StAccess);
  assign penable   = (state_q == StAccess);
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign pstrb     = pstrb_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

`ifdef APB4_MASTER_TIMEOUT_EN
  logic cnt_expired;
  logic rsp_timeout_q;

  // Cleared while in SETUP so the count starts at 0 on ACCESS entry.
  apb4_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .pclk   (pclk),
    .preset (preset),
    .clr    (state_q == StSetup),
    .inc    ((state_q == StAccess) && !pready),
    .expired(cnt_expired)
  );

  // pready on the terminal cycle wins over the abort.
  assign timeout_hit = (state_q == StAccess) && !pready && cnt_expired;
  assign rsp_timeout = rsp_timeout_q;

  always_ff @(posedge pclk) begin
    if (preset) begin
      rsp_timeout_q <= 1'b0;
    end else if ((state_q == StAccess) && (pready || timeout_hit)) begin
      rsp_timeout_q <= !pready;
    end
  end
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = ^APB4_TIMEOUT_CNT_W'(TIMEOUT_CYCLES);
  assign timeout_hit        = 1'b0;
  assign rsp_timeout        = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (cmd_valid) state_d = StSetup;
      StSetup:  state_d = StAccess;
      StAccess: if (pready || timeout_hit) state_d = StResp;
      // No new command on the response handshake cycle; idle comes first.
      StResp:   if (rsp_ready) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q     <= StIdle;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      // Request fields only load on acceptance, so they hold through ACCESS.
      if ((state_q == StIdle) && cmd_valid) begin
        pwrite_q <= cmd_write;
        paddr_q  <= cmd_addr;
        pwdata_q <= cmd_wdata;
        pstrb_q  <= cmd_write ? cmd_strb : APB4_READ_STRB;
      end
      if (state_q == StAccess) begin
        if (pready) begin
          rsp_rdata_q <= pwrite_q ? 32'h0 : prdata;
          rsp_err_q   <= pslverr;
        end else if (timeout_hit) begin
          rsp_rdata_q <= 32'h0;
          rsp_err_q   <= 1'b1;
        end
      end
    end
  end

endmodule
